imem_loader: RTL and testbench

Program loader that writes the instruction memory's contents from a byte stream. It sits between a byte-oriented receiver (UART RX or debug port) and the instruction memory write port. It accepts a length-prefixed stream of 32-bit little-endian instruction words and issues one aligned word write per instruction. It holds the CPU in reset until the program has been loaded.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed little-endian byte stream into aligned
// instruction-memory word writes, holding the CPU in reset until the load completes.
module imem_loader #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          cpu_hold_o,
  output logic          done_o,
  output logic          err_o,
  output logic [CW-1:0] words_loaded_o
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StDone, StError
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] words_q, words_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          fire;
  logic [15:0]   n_full;
  logic [31:0]   asm_next;
  logic [CW-1:0] words_inc;

  assign fire      = rx_valid_i && rx_ready_q;
  assign n_full    = {rx_data_i, n_q[7:0]};
  assign asm_next  = {rx_data_i, asm_q[31:8]};
  assign words_inc = words_q + CW'(1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) state_d = StLenLo;
      end
      StLenLo: begin
        if (fire) begin
          n_d     = {8'h00, rx_data_i};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (fire) begin
          n_d = n_full;
          if (32'(n_full) > DEPTH) begin
            state_d = StError;
          end else begin
            // Zero-length also clears the count so words_loaded reflects this load.
            idx_d   = 2'd0;
            words_d = '0;
            state_d = (n_full == 16'd0) ? StDone : StData;
          end
        end
      end
      StData: begin
        if (fire) begin
          asm_d = asm_next;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = 32'(words_q) << 2;
            wdata_d = asm_next;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        words_d = words_inc;
        state_d = (32'(words_inc) == 32'(n_q)) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they align with it.
    rx_ready_d = (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData);
    we_d       = (state_d == StWrite);
    done_d     = (state_d == StDone);
    err_d      = (state_d == StError);
    hold_d     = (state_d != StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready_o     = rx_ready_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign cpu_hold_o     = hold_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, stalled, full, oversize, zero-length,
// mid-load reset and reload scenarios with hand-computed expected writes.
module tb_imem_loader;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [CW-1:0] words_loaded;

  int nchk  = 0;
  int nfail = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic [31:0] prog[6] = '{32'h00000013, 32'h00400093, 32'h00C00113,
                           32'h002081B3, 32'h00312023, 32'h00008067};

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .cpu_hold_o     (cpu_hold),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      chk("rdy_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      nchk++;
      nfail++;
      $error("FAIL accept_timeout: got %0h expected %0h", acc, 1'b1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_wr();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_prog();
    chk("prog_count", wr_addr.size(), 32'd6);
    for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
      chk("prog_addr", wr_addr[i], 32'(i * 4));
      chk("prog_data", wr_data[i], prog[i]);
    end
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal back-to-back load
    pulse_start();
    send_byte(8'h06, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_word(prog[i], 0);
    @(negedge clk);
    chk("norm_last_we", {31'd0, mem_we}, 32'd1);
    chk("norm_last_addr", mem_addr, 32'h14);
    chk("norm_hold_in_write", {31'd0, cpu_hold}, 32'd1);
    chk("norm_done_in_write", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("norm_done", {31'd0, done}, 32'd1);
    chk("norm_hold", {31'd0, cpu_hold}, 32'd0);
    chk("norm_words", 32'(words_loaded), 32'd6);
    chk("norm_we_off", {31'd0, mem_we}, 32'd0);
    check_prog();

    // Stalled stream with random gaps
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    send_byte(8'h06, $urandom_range(0, 5)); send_byte(8'h00, $urandom_range(0, 5));
    for (int i = 0; i < 6; i++) send_word(prog[i], 5);
    repeat (3) @(negedge clk);
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_words", 32'(words_loaded), 32'd6);
    check_prog();

    // Full-depth load
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 128; i++) begin
      w = {8'(i), 8'(i) ^ 8'hFF, 8'hC3, 8'(i)};
      send_word(w, 0);
    end
    repeat (2) @(negedge clk);
    chk("full_count", wr_addr.size(), 32'd128);
    for (int i = 0; i < 128 && i < wr_addr.size(); i++) begin
      chk("full_addr", wr_addr[i], 32'(i * 4));
      chk("full_data", wr_data[i], {8'(i), 8'(i) ^ 8'hFF, 8'hC3, 8'(i)});
    end
    if (wr_addr.size() > 0) chk("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h1FC);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_words", 32'(words_loaded), 32'd128);

    // Oversize length
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    send_byte(8'h81, 0); send_byte(8'h00, 0);
    @(negedge clk);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_hold", {31'd0, cpu_hold}, 32'd1);
    chk("over_done", {31'd0, done}, 32'd0);
    chk("over_rdy", {31'd0, rx_ready}, 32'd0);
    repeat (5) @(negedge clk);
    chk("over_no_write", wr_addr.size(), 32'd0);
    chk("over_err_held", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("over_err_clr", {31'd0, err}, 32'd0);
    chk("over_lenlo_rdy", {31'd0, rx_ready}, 32'd1);

    // Zero length directly after the error recovery start
    @(posedge clk); #1;
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_hold", {31'd0, cpu_hold}, 32'd0);
    chk("zero_words", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    chk("zero_no_write", wr_addr.size(), 32'd0);

    // Reset partway through word 3
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_word(prog[0], 0); send_word(prog[1], 0);
    send_byte(prog[2][7:0], 0); send_byte(prog[2][15:8], 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_we", {31'd0, mem_we}, 32'd0);
    chk("mrst_rdy", {31'd0, rx_ready}, 32'd0);
    chk("mrst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mrst_words", 32'(words_loaded), 32'd0);
    chk("mrst_writes", wr_addr.size(), 32'd2);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_idle_rdy", {31'd0, rx_ready}, 32'd0);
    chk("mrst_idle_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h11223344, 0);
    @(negedge clk);
    chk("mrst_re_we", {31'd0, mem_we}, 32'd1);
    chk("mrst_re_addr", mem_addr, 32'h0);
    chk("mrst_re_data", mem_wdata, 32'h11223344);
    @(negedge clk);
    chk("mrst_re_done", {31'd0, done}, 32'd1);

    // Reload from DONE with a stray start mid-load
    chk("rl_pre_hold", {31'd0, cpu_hold}, 32'd0);
    @(posedge clk); #1;
    clear_wr();
    pulse_start();
    @(negedge clk);
    chk("rl_hold_up", {31'd0, cpu_hold}, 32'd1);
    chk("rl_done_down", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hEF, 0);
    pulse_start();
    send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    @(negedge clk);
    chk("rl_we", {31'd0, mem_we}, 32'd1);
    chk("rl_addr", mem_addr, 32'h0);
    chk("rl_data", mem_wdata, 32'hDEADBEEF);
    chk("rl_hold_in_write", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    chk("rl_done", {31'd0, done}, 32'd1);
    chk("rl_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rl_writes", wr_addr.size(), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", nchk);
    $fatal(1, "global timeout");
  end

endmodule
